// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the pipelined MIPS core.
// It holds the decoded operands and control for the E stage, forwards results
// from the MEM and WB stages, applies the ALUSrc immediate mux, and detects
// load-use hazards.
//
// Stall/flush semantics (there is no valid/ready handshake here):
//   - flush_e replaces the E contents with a bubble and overrides stall_e.
//   - stall_e freezes every E field. The whole pipe is frozen, so no
//     load-use bubble is inserted and stall_d stays low.
//   - Otherwise a load-use hazard (lw_stall) loads a bubble while decode holds.
//   - Otherwise E loads from D. A decode slot with valid_d=0 loads a bubble.
// A bubble is all-zero: valid and control are off and the ALU computes 0+0.
module id_ex_stage #(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_d,
    input  logic [31:0] rd1_d,
    input  logic [31:0] rd2_d,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [4:0]  rd_d,
    input  logic [31:0] signimm_d,
    input  logic [4:0]  shamt_d,
    input  logic [2:0]  alu_control_d,
    input  logic        alu_src_d,
    input  logic        reg_dst_d,
    input  logic        reg_write_d,
    input  logic        mem_write_d,
    input  logic        mem_to_reg_d,
    input  logic        stall_e,
    input  logic        flush_e,
    input  logic        reg_write_m,
    input  logic [4:0]  write_reg_m,
    input  logic [31:0] alu_out_m,
    input  logic        reg_write_w,
    input  logic [4:0]  write_reg_w,
    input  logic [31:0] result_w,
    output logic        stall_d,
    output logic        valid_e,
    output logic [31:0] a_e,
    output logic [31:0] b_e,
    output logic [2:0]  alu_control_e,
    output logic [4:0]  shamt_e,
    output logic [31:0] write_data_e,
    output logic [4:0]  write_reg_e,
    output logic        reg_write_e,
    output logic        mem_write_e,
    output logic        mem_to_reg_e
);

    // All E-stage fields in one record so that a bubble is simply '0.
    typedef struct packed {
        logic        valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] signimm;
        logic [4:0]  shamt;
        logic [2:0]  alu_control;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_write;
        logic        mem_to_reg;
    } e_fields_t;

    e_fields_t   e_q;
    e_fields_t   e_d;
    logic        lw_stall;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    // Load-use hazard: the load in E cannot supply its data to the consumer in D.
    always_comb begin
        lw_stall = e_q.valid && e_q.mem_to_reg && valid_d && (e_q.rt != 5'd0) &&
                   ((e_q.rt == rs_d) || (e_q.rt == rt_d));
        stall_d  = lw_stall && !stall_e;
    end

    // Next E contents: flush > stall > load-use bubble > load from D.
    always_comb begin
        e_d = e_q;
        if (flush_e) begin
            e_d = '0;
        end else if (stall_e) begin
            e_d = e_q;
        end else if (lw_stall || !valid_d) begin
            e_d = '0;
        end else begin
            e_d.valid       = 1'b1;
            e_d.rd1         = rd1_d;
            e_d.rd2         = rd2_d;
            e_d.rs          = rs_d;
            e_d.rt          = rt_d;
            e_d.rd          = rd_d;
            e_d.signimm     = signimm_d;
            e_d.shamt       = shamt_d;
            e_d.alu_control = alu_control_d;
            e_d.alu_src     = alu_src_d;
            e_d.reg_dst     = reg_dst_d;
            e_d.reg_write   = reg_write_d;
            e_d.mem_write   = mem_write_d;
            e_d.mem_to_reg  = mem_to_reg_d;
        end
    end

    // E-stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    // Operand forwarding: MEM beats WB, register 0 is never forwarded.
    always_comb begin
        fwd_a = e_q.rd1;
        if (FORWARD_EN && reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == e_q.rs)) begin
            fwd_a = alu_out_m;
        end else if (FORWARD_EN && reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == e_q.rs)) begin
            fwd_a = result_w;
        end
        fwd_b = e_q.rd2;
        if (FORWARD_EN && reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == e_q.rt)) begin
            fwd_b = alu_out_m;
        end else if (FORWARD_EN && reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == e_q.rt)) begin
            fwd_b = result_w;
        end
    end

    // Output muxes and pass-through of registered control.
    always_comb begin
        valid_e       = e_q.valid;
        a_e           = fwd_a;
        b_e           = e_q.alu_src ? e_q.signimm : fwd_b;
        write_data_e  = fwd_b;
        write_reg_e   = e_q.reg_dst ? e_q.rd : e_q.rt;
        alu_control_e = e_q.alu_control;
        shamt_e       = e_q.shamt;
        reg_write_e   = e_q.reg_write;
        mem_write_e   = e_q.mem_write;
        mem_to_reg_e  = e_q.mem_to_reg;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage for the pipelined MIPS core. It sits directly upstream of the ALU and drives the ALU's a, b, aluControl and shamt inputs.
- It registers decoded operands and control, forwards results from the MEM and WB stages, and applies the ALUSrc immediate mux.
- It detects load-use hazards and inserts bubbles, honours external stall and flush requests, and passes store data and destination-register information downstream.

Parameters:
- FORWARD_EN, 1: 1 enables MEM/WB forwarding; 0 makes operand muxes always select the registered register-file values (debug only).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- valid_d  in  1  decode holds a real instruction
- rd1_d, rd2_d  in  32  register-file read data (rs, rt)
- rs_d, rt_d, rd_d  in  5  register specifiers
- signimm_d  in  32  sign-extended immediate
- shamt_d  in  5  shift amount
- alu_control_d  in  3  ALU op (0 add, 1 sub, 2 and, 3 or, 4 nor, 5 slt, 6 sll, 7 srl)
- alu_src_d, reg_dst_d, reg_write_d, mem_write_d, mem_to_reg_d  in  1 each  decoded control
- stall_e  in  1  hold E-stage contents
- flush_e  in  1  replace E-stage contents with a bubble
- reg_write_m  in  1  MEM-stage write enable
- write_reg_m  in  5  MEM-stage destination register
- alu_out_m  in  32  MEM-stage result
- reg_write_w  in  1  WB-stage write enable
- write_reg_w  in  5  WB-stage destination register
- result_w  in  32  WB-stage result
- stall_d  out  1  load-use hazard; fetch/decode must hold
- valid_e  out  1  E stage holds a real instruction
- a_e, b_e  out  32  ALU operands
- alu_control_e  out  3  ALU op
- shamt_e  out  5  ALU shift amount
- write_data_e  out  32  forwarded rt value for stores
- write_reg_e  out  5  destination register
- reg_write_e, mem_write_e, mem_to_reg_e  out  1 each  control passed to MEM

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset: clears every registered field to 0, including valid_e, control, specifiers, data, signimm and shamt. With all fields 0, every output is 0 and stall_d is 0 on the cycle after reset, whatever the forwarding inputs are.
- Register update priority each rising edge: reset > flush_e (bubble) > stall_e (hold all fields) > lw_stall (bubble) > load from D.
- flush_e with stall_e: the bubble wins.
- Bubble: valid_e, reg_write_e, mem_write_e, mem_to_reg_e are cleared, as are all other fields. A bubble therefore computes 0+0 and writes nothing.
- Load from D when valid_d=0: loads a bubble.
- Latency: one cycle from D inputs to the registered E fields.
- lw_stall is combinational: valid_e & mem_to_reg_e & valid_d & (rt_e != 0) & (rt_e == rs_d | rt_e == rt_d).
- stall_d = lw_stall & ~stall_e. When stall_e is set, the whole pipe is frozen, so no bubble is inserted.
- Forward A is combinational:
  - if FORWARD_EN & reg_write_m & write_reg_m != 0 & write_reg_m == rs_e, select alu_out_m;
  - else if FORWARD_EN & reg_write_w & write_reg_w != 0 & write_reg_w == rs_e, select result_w;
  - else select rd1_e.
  - MEM has priority over WB.
- Forward B: same rule as Forward A, using rt_e and rd2_e.
- Register 0 is never forwarded.
- a_e = forward A.
- b_e = alu_src_e ? signimm_e : forward B.
- write_data_e = forward B always, independent of alu_src_e.
- write_reg_e = reg_dst_e ? rd_e : rt_e.
- alu_control_e and shamt_e are the registered values, passed through unchanged.
- All datapath widths are 32 bits. No arithmetic is done in this block.
- Reset asserted mid-stall or mid-hazard: all state clears on that edge; stall_d is 0 on the following cycle.

Test Plan:
1. Reset: hold reset 2 cycles with random D and forwarding inputs -> all outputs 0, stall_d 0; release -> first valid load appears one cycle later.
2. Plain R-type: valid_d=1, rd1_d=125, rd2_d=360, rs_d=1, rt_d=2, rd_d=3, reg_dst_d=1, alu_control_d=0, no forwarding -> next cycle a_e=125, b_e=360, write_reg_e=3, reg_write_e as loaded, valid_e=1.
3. Forwarding priority:
   - rs_e=5, rd1_e=7; reg_write_m=1, write_reg_m=5, alu_out_m=100; reg_write_w=1, write_reg_w=5, result_w=200 -> a_e=100.
   - Drop reg_write_m -> a_e=200.
   - Set write_reg_m=write_reg_w=0 with rs_e=0 -> a_e=rd1_e (0 or loaded value).
   - FORWARD_EN=0 -> a_e=7.
4. Load-use:
   - E holds lw (mem_to_reg_e=1, rt_e=8), D has rs_d=8, valid_d=1 -> stall_d=1; next cycle valid_e=0, reg_write_e=0, mem_write_e=0, a_e=0.
   - Repeat with rt_e=0 -> stall_d=0.
   - Repeat with stall_e=1 -> stall_d=0 and E unchanged.
5. Stall/flush:
   - stall_e=1 for 3 cycles while D inputs change each cycle -> all E outputs constant.
   - Then flush_e=1 together with stall_e=1 -> next cycle bubble (valid_e=0).
6. Immediate and store path:
   - alu_src_d=1, signimm_d=32'hFFFFFFFC, shamt_d=16, alu_control_d=6, rt_d=4, rd2_d=9 -> b_e=32'hFFFFFFFC, shamt_e=16, alu_control_e=6, write_data_e=9.
   - With reg_write_m=1, write_reg_m=4, alu_out_m=55 -> write_data_e=55 and b_e still 32'hFFFFFFFC.
